pcpi_simd_mul_seq: RTL and testbench

- Parametrised successor to the single-cycle packed 8-bit PCPI multiplier.
- Sits on the PicoRV32 PCPI port and executes custom-0 SIMD multiply instructions on packed lanes of configurable width, using an iterative shift-add datapath of configurable radix.
- Adds signed high-half, per-lane multiply-accumulate and accumulator-clear modes.
- Asserts pcpi_wait while busy so the core's coprocessor timeout never fires.

---
 rtl/pcpi_simd_mul_seq.sv | 198 +++++++++++++++++++
 tb/tb_pcpi_simd_mul_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pcpi_simd_mul_seq.sv
// PicoRV32 PCPI coprocessor: packed-lane SIMD multiply, multiply-high and per-lane MAC
// built on an iterative shift-add datapath that retires RADIX_BITS multiplier bits per cycle.
module pcpi_simd_mul_seq #(
    parameter int         LANE_W     = 8,
    parameter int         RADIX_BITS = 1,
    parameter logic [6:0] OPCODE     = 7'b0001011,
    parameter logic [6:0] FUNCT7     = 7'b0000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    localparam int NLANES = 32 / LANE_W;
    localparam int N      = LANE_W / RADIX_BITS;
    localparam int PW     = 2 * LANE_W;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] F_MULW  = 3'b000;
    localparam logic [2:0] F_MULL  = 3'b001;
    localparam logic [2:0] F_MULHU = 3'b010;
    localparam logic [2:0] F_MULH  = 3'b011;
    localparam logic [2:0] F_MACL  = 3'b100;
    localparam logic [2:0] F_CLR   = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               op_q, op_d;
    logic [NLANES*PW-1:0]     mcand_q, mcand_d, prod_q, prod_d;
    logic [31:0]              mplier_q, mplier_d;
    logic [NLANES-1:0]        neg_q, neg_d;
    logic [31:0]              acc_q, acc_d, rd_q, rd_d;

    logic [2:0]               funct3;
    logic                     active;
    logic                     unused_insn;

    assign funct3      = pcpi_insn[14:12];
    assign active      = pcpi_valid && (pcpi_insn[6:0] == OPCODE) &&
                         (pcpi_insn[31:25] == FUNCT7) && (funct3 <= F_CLR);
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // Per-lane operand preparation, one shift-add step and result packing.
    logic [NLANES*PW-1:0]     mcand_init, mcand_shift, prod_step, prod_fin;
    logic [31:0]              mplier_init, mplier_shift;
    logic [NLANES-1:0]        neg_init;
    logic [31:0]              res_mulw, res_lo, res_hi, acc_sum, result;
    logic [LANE_W-1:0]        lane_a, lane_b;
    logic [RADIX_BITS-1:0]    digit;
    logic [PW-1:0]            lane_p, lane_s, lane_f;
    logic                     is_signed;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        mcand_init   = '0;
        mcand_shift  = '0;
        prod_step    = '0;
        prod_fin     = '0;
        mplier_init  = '0;
        mplier_shift = '0;
        neg_init     = '0;
        res_mulw     = '0;
        res_lo       = '0;
        res_hi       = '0;
        acc_sum      = '0;
        lane_a       = '0;
        lane_b       = '0;
        digit        = '0;
        lane_p       = '0;
        lane_s       = '0;
        lane_f       = '0;
        is_signed    = (funct3 == F_MULH);
        for (int i = 0; i < NLANES; i++) begin
            // MULH multiplies magnitudes; -0x80 as an unsigned LANE_W value is 0x80, which is exact.
            lane_a = pcpi_rs1[i*LANE_W +: LANE_W];
            lane_b = pcpi_rs2[i*LANE_W +: LANE_W];
            neg_init[i] = is_signed && (lane_a[LANE_W-1] ^ lane_b[LANE_W-1]);
            if (is_signed && lane_a[LANE_W-1]) lane_a = -lane_a;
            if (is_signed && lane_b[LANE_W-1]) lane_b = -lane_b;
            mcand_init[i*PW +: PW]          = {{LANE_W{1'b0}}, lane_a};
            mplier_init[i*LANE_W +: LANE_W] = lane_b;

            digit  = mplier_q[i*LANE_W +: RADIX_BITS];
            lane_p = mcand_q[i*PW +: PW] * {{(PW-RADIX_BITS){1'b0}}, digit};
            lane_s = prod_q[i*PW +: PW] + lane_p;
            lane_f = neg_q[i] ? -lane_s : lane_s;
            prod_step[i*PW +: PW]            = lane_s;
            prod_fin[i*PW +: PW]             = lane_f;
            mcand_shift[i*PW +: PW]          = mcand_q[i*PW +: PW] << RADIX_BITS;
            mplier_shift[i*LANE_W +: LANE_W] = mplier_q[i*LANE_W +: LANE_W] >> RADIX_BITS;
            res_lo[i*LANE_W +: LANE_W]       = lane_f[LANE_W-1:0];
            res_hi[i*LANE_W +: LANE_W]       = lane_f[PW-1:LANE_W];
            acc_sum[i*LANE_W +: LANE_W]      = acc_q[i*LANE_W +: LANE_W] + lane_f[LANE_W-1:0];
        end
        for (int i = 0; i < NLANES / 2; i++) begin
            res_mulw[i*PW +: PW] = prod_fin[i*PW +: PW];
        end
    end

    always_comb begin
        case (op_q)
            F_MULW:          result = res_mulw;
            F_MULL:          result = res_lo;
            F_MULHU, F_MULH: result = res_hi;
            F_MACL:          result = acc_sum;
            default:         result = rd_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: begin
                if (active) begin
                    op_d = funct3;
                    if (funct3 == F_CLR) begin
                        rd_d    = acc_q;
                        acc_d   = '0;
                        state_d = DONE;
                    end else begin
                        mcand_d  = mcand_init;
                        mplier_d = mplier_init;
                        neg_d    = neg_init;
                        prod_d   = '0;
                        cnt_d    = CNT_W'(N - 1);
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                // A withdrawn instruction is dropped silently; the accumulators stay untouched.
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end else begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_shift;
                    mplier_d = mplier_shift;
                    if (cnt_q == '0) begin
                        rd_d = result;
                        if (op_q == F_MACL) acc_d = acc_sum;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the accumulators are real architectural state and are reset too.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            neg_q    <= '0;
            acc_q    <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            rd_q     <= rd_d;
        end
    end

    assign pcpi_ready = (state_q == DONE);
    assign pcpi_wr    = (state_q == DONE);
    assign pcpi_wait  = (state_q == BUSY);
    assign pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_simd_mul_seq.sv
// Directed bench for pcpi_simd_mul_seq: an 8-bit/radix-2 instance and a 16-bit/radix-16 instance
// share clock and reset; expected values are hand-computed products.
module tb_pcpi_simd_mul_seq;
    logic        clk;
    logic        resetn;
    logic        valid [2];
    logic [31:0] insn  [2];
    logic [31:0] rs1   [2];
    logic [31:0] rs2   [2];
    logic        wr    [2];
    logic        wt    [2];
    logic        rdy   [2];
    logic [31:0] rd    [2];

    int checks   = 0;
    int failures = 0;

    pcpi_simd_mul_seq u_dut8 (
        .clk(clk), .resetn(resetn),
        .pcpi_valid(valid[0]), .pcpi_insn(insn[0]), .pcpi_rs1(rs1[0]), .pcpi_rs2(rs2[0]),
        .pcpi_wr(wr[0]), .pcpi_rd(rd[0]), .pcpi_wait(wt[0]), .pcpi_ready(rdy[0])
    );

    pcpi_simd_mul_seq #(.LANE_W(16), .RADIX_BITS(4)) u_dut16 (
        .clk(clk), .resetn(resetn),
        .pcpi_valid(valid[1]), .pcpi_insn(insn[1]), .pcpi_rs1(rs1[1]), .pcpi_rs2(rs2[1]),
        .pcpi_wr(wr[1]), .pcpi_rd(rd[1]), .pcpi_wait(wt[1]), .pcpi_ready(rdy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
    endfunction

    // Issue one instruction, scramble operands after acceptance, then check every cycle up to
    // the completion pulse at T+lat and the idle cycle after it.
    task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rd, input int lat, input string tag);
        @(negedge clk);
        valid[d] = 1'b1;
        insn[d]  = mk_insn(7'h00, f3);
        rs1[d]   = a;
        rs2[d]   = b;
        @(posedge clk);
        #1;
        rs1[d] = ~a;
        rs2[d] = b ^ 32'h5A5A_A5A5;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                check({tag, " wait"}, {31'b0, wt[d]}, 32'd1);
                check({tag, " early_ready"}, {31'b0, rdy[d]}, 32'd0);
            end else begin
                check({tag, " ready"}, {30'b0, rdy[d], wr[d]}, 32'd3);
                check({tag, " wait_done"}, {31'b0, wt[d]}, 32'd0);
                check({tag, " rd"}, rd[d], exp_rd);
                valid[d] = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, " idle"}, {29'b0, wt[d], rdy[d], wr[d]}, 32'd0);
        check({tag, " rd_hold"}, rd[d], exp_rd);
    endtask

    initial begin
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0;
            insn[d]  = '0;
            rs1[d]   = '0;
            rs2[d]   = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("reset_ctl", {29'b0, wt[d], rdy[d], wr[d]}, 32'd0);
            check("reset_rd", rd[d], 32'd0);
        end
        @(negedge clk);
        resetn = 1'b1;

        // Full-width unsigned products, 8-bit lanes, radix 2: 8 busy cycles.
        issue(0, 3'b000, 32'h0000FF03, 32'h0000FF05, 32'hFE01000F, 9, "mulw8");

        // Signed/unsigned high halves and low halves, including the 0x80*0x80 corner.
        issue(0, 3'b011, 32'h02FF7F80, 32'hFE017F80, 32'hFFFF3F40, 9, "mulh8");
        issue(0, 3'b010, 32'h02FF7F80, 32'hFE017F80, 32'h01003F40, 9, "mulhu8");
        issue(0, 3'b001, 32'h02FF7F80, 32'hFE017F80, 32'hFCFF0100, 9, "mull8");

        // Accumulator clear and multiply-accumulate.
        issue(0, 3'b101, 32'h0, 32'h0, 32'h00000000, 1, "clr0");
        issue(0, 3'b100, 32'h01020304, 32'h10101010, 32'h10203040, 9, "macl1");
        issue(0, 3'b100, 32'h01020304, 32'h10101010, 32'h20406080, 9, "macl2");
        issue(0, 3'b101, 32'h0, 32'h0, 32'h20406080, 1, "clr1");
        issue(0, 3'b100, 32'h01020304, 32'h10101010, 32'h10203040, 9, "macl3");

        // Abort a MACL in its 3rd busy cycle; acc must remain 0x10203040.
        @(negedge clk);
        valid[0] = 1'b1;
        insn[0]  = mk_insn(7'h00, 3'b100);
        rs1[0]   = 32'h01020304;
        rs2[0]   = 32'h10101010;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("abort_wait", {31'b0, wt[0]}, 32'd1);
        end
        valid[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("abort_quiet", {29'b0, wt[0], rdy[0], wr[0]}, 32'd0);
        end
        issue(0, 3'b001, 32'h03030303, 32'h03030303, 32'h09090909, 9, "mull_post");
        issue(0, 3'b101, 32'h0, 32'h0, 32'h10203040, 1, "clr_post_abort");

        // Asynchronous reset in the middle of a busy operation.
        issue(0, 3'b100, 32'h03030303, 32'h03030303, 32'h09090909, 9, "macl_pre_rst");
        @(negedge clk);
        valid[0] = 1'b1;
        insn[0]  = mk_insn(7'h00, 3'b000);
        rs1[0]   = 32'h0000FF03;
        rs2[0]   = 32'h0000FF05;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) @(negedge clk);
        check("rst_pre_wait", {31'b0, wt[0]}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_ctl", {29'b0, wt[0], rdy[0], wr[0]}, 32'd0);
        check("rst_async_rd", rd[0], 32'd0);
        valid[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        issue(0, 3'b101, 32'h0, 32'h0, 32'h00000000, 1, "clr_post_rst");

        // Unclaimed instructions: funct3 110 and funct7 0x01.
        @(negedge clk);
        valid[0] = 1'b1;
        insn[0]  = mk_insn(7'h00, 3'b110);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("unclaimed_f3", {29'b0, wt[0], rdy[0], wr[0]}, 32'd0);
        end
        insn[0] = mk_insn(7'h01, 3'b000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("unclaimed_f7", {29'b0, wt[0], rdy[0], wr[0]}, 32'd0);
        end
        valid[0] = 1'b0;

        // 16-bit lanes, radix 16: 4 busy cycles.
        issue(1, 3'b000, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 5, "mulw16");
        issue(1, 3'b011, 32'h80007FFF, 32'h80007FFF, 32'h40003FFF, 5, "mulh16");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
